// File: rtl/msk_xor_acc.sv
// Masked streaming XOR accumulator: folds NBEATS d-share sharings share-wise into one result.
// Optional in-flight share refresh is compiled in with MSK_XOR_ACC_REFRESH_EN.
module msk_xor_acc #(
  parameter int d      = 2,
  parameter int count  = 8,
  parameter int NBEATS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [count*d-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [count*d-1:0]     out_data
`ifdef MSK_XOR_ACC_REFRESH_EN
  ,
  input  logic [count*(d-1)-1:0] rnd
`endif
);

  localparam int CW = (NBEATS < 2) ? 1 : $clog2(NBEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  (* keep = "true", syn_keep = 1 *) logic [count*d-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [count*d-1:0] w_mask;
  logic [count*d-1:0] w_beat;

`ifdef MSK_XOR_ACC_REFRESH_EN
  if (d < 2) begin : g_bad_d
    $error("msk_xor_acc: refresh requires d >= 2");
  end

  // Zero-sum mask per bit: the last share absorbs the XOR of the others' masks.
  for (genvar gj = 0; gj < count; gj++) begin : g_bit
    for (genvar gi = 0; gi < d - 1; gi++) begin : g_share
      assign w_mask[gj*d+gi] = rnd[gj*(d-1)+gi];
    end
    assign w_mask[gj*d+d-1] = ^rnd[gj*(d-1) +: d-1];
  end
`else
  assign w_mask = '0;
`endif

  assign w_beat    = in_data ^ w_mask;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_state     <= ST_ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_state     <= ST_ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (in_valid) begin
            r_acc <= r_acc ^ w_beat;
            if (r_cnt == LAST) begin
              r_cnt       <= '0;
              r_state     <= ST_OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_state     <= ST_ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msk_xor_acc.sv
// Directed self-checking bench for msk_xor_acc (d=2 NBEATS=4, d=2 NBEATS=1, and d=3 refresh when enabled).
module tb_msk_xor_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  logic        n1_in_valid = 1'b0;
  logic        n1_in_ready;
  logic [15:0] n1_in_data = '0;
  logic        n1_out_valid;
  logic        n1_out_ready = 1'b0;
  logic [15:0] n1_out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef MSK_XOR_ACC_REFRESH_EN
  logic [7:0]  rnd_zero = '0;
  logic        r3_in_valid = 1'b0;
  logic        r3_in_ready;
  logic [23:0] r3_in_data = '0;
  logic        r3_out_valid;
  logic        r3_out_ready = 1'b0;
  logic [23:0] r3_out_data;
  logic [15:0] r3_rnd = '0;
`endif

  msk_xor_acc #(.d(2), .count(8), .NBEATS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MSK_XOR_ACC_REFRESH_EN
    , .rnd(rnd_zero)
`endif
  );

  msk_xor_acc #(.d(2), .count(8), .NBEATS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(n1_in_valid), .in_ready(n1_in_ready), .in_data(n1_in_data),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_data(n1_out_data)
`ifdef MSK_XOR_ACC_REFRESH_EN
    , .rnd(rnd_zero)
`endif
  );

`ifdef MSK_XOR_ACC_REFRESH_EN
  msk_xor_acc #(.d(3), .count(8), .NBEATS(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(r3_in_valid), .in_ready(r3_in_ready), .in_data(r3_in_data),
    .out_valid(r3_out_valid), .out_ready(r3_out_ready), .out_data(r3_out_data),
    .rnd(r3_rnd)
  );
`endif

  function automatic logic [15:0] pack2(input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] v;
    for (int j = 0; j < 8; j++) begin
      v[2*j]   = s0[j];
      v[2*j+1] = s1[j];
    end
    return v;
  endfunction

  function automatic logic [23:0] pack3(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    logic [23:0] v;
    for (int j = 0; j < 8; j++) begin
      v[3*j]   = s0[j];
      v[3*j+1] = s1[j];
      v[3*j+2] = s2[j];
    end
    return v;
  endfunction

  function automatic logic [7:0] unmask3(input logic [23:0] v);
    logic [7:0] u;
    for (int j = 0; j < 8; j++) u[j] = v[3*j] ^ v[3*j+1] ^ v[3*j+2];
    return u;
  endfunction

  // Offers one beat on the main DUT from a negedge; returns at the negedge after the handshake.
  task automatic drive_beat(input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    tests++;
    if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data: got %h required 0000", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_basic_fold;
    logic [15:0] beats [4];
    beats[0] = pack2(8'h11, 8'h22);
    beats[1] = pack2(8'h0F, 8'h00);
    beats[2] = pack2(8'hF0, 8'h01);
    beats[3] = pack2(8'h00, 8'h80);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive_beat(beats[k]);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL fold_early_valid: got %0b required 0", out_valid); end
    drive_beat(beats[3]);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL fold_out_valid: got %0b required 1", out_valid); end
    tests++;
    if (out_data !== pack2(8'hEE, 8'hA3)) begin
      fails++; $display("FAIL fold_out_data: got %h required %h", out_data, pack2(8'hEE, 8'hA3));
    end
    $display("[TB] basic fold out_data=%h", out_data);
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== pack2(8'hEE, 8'hA3)) begin
        fails++;
        $display("FAIL backpressure_hold: valid=%0b ready=%0b data=%h required 1 0 %h",
                 out_valid, in_ready, out_data, pack2(8'hEE, 8'hA3));
      end
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin
      fails++;
      $display("FAIL backpressure_release: valid=%0b ready=%0b data=%h required 0 1 0000",
               out_valid, in_ready, out_data);
    end
    $display("[TB] backpressure released");
  endtask

  task automatic test_gapped;
    logic [15:0] beats [4];
    logic [6:0]  pat;
    int k = 0;
    beats[0] = pack2(8'h11, 8'h22);
    beats[1] = pack2(8'h0F, 8'h00);
    beats[2] = pack2(8'hF0, 8'h01);
    beats[3] = pack2(8'h00, 8'h80);
    pat = 7'b1001101;
    for (int c = 6; c >= 0; c--) begin
      if (pat[c]) begin
        in_valid = 1'b1;
        in_data  = beats[k];
        k++;
      end else begin
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
      end
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL gapped_early_valid: got %0b required 0", out_valid); end
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== pack2(8'hEE, 8'hA3)) begin
      fails++;
      $display("FAIL gapped_result: valid=%0b data=%h required 1 %h", out_valid, out_data, pack2(8'hEE, 8'hA3));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("[TB] gapped fold done");
  endtask

  task automatic test_abort;
    drive_beat(pack2(8'hDE, 8'hAD));
    drive_beat(pack2(8'hBE, 8'hEF));
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = pack2(8'h5A, 8'hC3);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tests++;
    if (out_data !== 16'h0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL clr_mid_fold: valid=%0b data=%h required 0 0000", out_valid, out_data);
    end
    drive_beat(pack2(8'h01, 8'h02));
    drive_beat(pack2(8'h04, 8'h08));
    drive_beat(pack2(8'h10, 8'h20));
    drive_beat(pack2(8'h40, 8'h80));
    tests++;
    if (out_valid !== 1'b1 || out_data !== pack2(8'h55, 8'hAA)) begin
      fails++;
      $display("FAIL clr_refold: valid=%0b data=%h required 1 %h", out_valid, out_data, pack2(8'h55, 8'hAA));
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin
      fails++; $display("FAIL clr_in_out: valid=%0b ready=%0b data=%h required 0 1 0000", out_valid, in_ready, out_data);
    end
    for (int k = 0; k < 4; k++) drive_beat(pack2(8'h33, 8'h0C));
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      fails++; $display("FAIL async_reset_in_out: valid=%0b data=%h required 0 0000", out_valid, out_data);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL async_reset_ready: got %0b required 1", in_ready); end
    $display("[TB] abort and reset checked");
  endtask

  task automatic test_nbeats1;
    logic [15:0] beats [3];
    beats[0] = pack2(8'hA5, 8'h3C);
    beats[1] = pack2(8'h00, 8'hFF);
    beats[2] = pack2(8'h7E, 8'h81);
    n1_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n1_in_valid = 1'b1;
      n1_in_data  = beats[k];
      @(negedge clk);
      n1_in_valid = 1'b0;
      n1_in_data  = '0;
      tests++;
      if (n1_out_valid !== 1'b1 || n1_in_ready !== 1'b0 || n1_out_data !== beats[k]) begin
        fails++;
        $display("FAIL nbeats1_result%0d: valid=%0b ready=%0b data=%h required 1 0 %h",
                 k, n1_out_valid, n1_in_ready, n1_out_data, beats[k]);
      end
      @(negedge clk);
      tests++;
      if (n1_out_valid !== 1'b0 || n1_in_ready !== 1'b1) begin
        fails++; $display("FAIL nbeats1_bubble%0d: valid=%0b ready=%0b required 0 1", k, n1_out_valid, n1_in_ready);
      end
    end
    n1_out_ready = 1'b0;
    $display("[TB] NBEATS=1 checked");
  endtask

`ifdef MSK_XOR_ACC_REFRESH_EN
  task automatic test_refresh;
    logic [23:0] beats [4];
    logic [15:0] rnds  [4];
    logic [7:0]  plain;
    logic [23:0] sharewise;
    beats[0] = pack3(8'h12, 8'h34, 8'h56);
    beats[1] = pack3(8'h9A, 8'hBC, 8'hDE);
    beats[2] = pack3(8'h01, 8'h80, 8'hFF);
    beats[3] = pack3(8'h5A, 8'hA5, 8'h3C);
    rnds[0] = 16'hC3A7; rnds[1] = 16'h0000; rnds[2] = 16'h0000; rnds[3] = 16'h0000;
    plain = '0;
    sharewise = '0;
    for (int k = 0; k < 4; k++) begin
      plain     = plain ^ unmask3(beats[k]);
      sharewise = sharewise ^ beats[k];
      r3_in_valid = 1'b1;
      r3_in_data  = beats[k];
      r3_rnd      = rnds[k];
      @(negedge clk);
    end
    r3_in_valid = 1'b0;
    r3_rnd      = 16'hFFFF;
    tests++;
    if (r3_out_valid !== 1'b1 || unmask3(r3_out_data) !== plain) begin
      fails++;
      $display("FAIL refresh_unmasked: valid=%0b value=%h required 1 %h", r3_out_valid, unmask3(r3_out_data), plain);
    end
    tests++;
    if (r3_out_data === sharewise) begin
      fails++; $display("FAIL refresh_rerandomised: shares=%h required different from %h", r3_out_data, sharewise);
    end
    r3_out_ready = 1'b1;
    @(negedge clk);
    r3_out_ready = 1'b0;
    $display("[TB] refresh checked");
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_fold();
    test_backpressure();
    test_gapped();
    test_abort();
    test_nbeats1();
`ifdef MSK_XOR_ACC_REFRESH_EN
    test_refresh();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msk_xor_acc.md
# msk_xor_acc

Masked streaming XOR accumulator for the masked gate library. It folds a fixed number of d-share sharings into one sharing, one beat per accepted input. The computation is share-wise, so the unmasked value of the result is the XOR of the unmasked inputs and no shares are ever combined. It sits between the permutation datapath and tag/keystream logic wherever several masked words must be XOR-reduced. It adds valid/ready handshaking, a result register and optional in-flight share refresh.

## Interface
- d, 2, number of shares per bit (≥1; ≥2 when refresh is compiled in)
- count, 8, number of masked bits per beat
- NBEATS, 4, input beats folded into one result (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: drop the partial/held result
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat can be accepted
- in_data  in  count*d  input sharing, bit-major: share i of bit j at index j*d+i
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result
- out_data  out  count*d  result sharing, same layout
- rnd  in  count*(d-1)  fresh randomness, bit j mask at [j*(d-1) +: d-1] (present only with MSK_XOR_ACC_REFRESH_EN)

## Operation
- State: accumulator acc[count*d], beat counter cnt[$clog2(NBEATS+1)], FSM {ACC, OUT}.
- ACC: in_ready=1, out_valid=0. On in_valid&&in_ready: acc ← acc ^ in_data and cnt ← cnt+1. If cnt==NBEATS-1, go to OUT with acc already holding the final value, and cnt ← 0.
- OUT: in_ready=0, out_valid=1, out_data=acc. acc stays stable while out_ready=0.
- On out_valid&&out_ready, go to ACC and clear acc to 0 in the same edge.
- First beat of a fold: the accumulator holds 0, so the beat is loaded directly (0 ^ in_data).
- clr=1 in any state: acc←0, cnt←0, state←ACC at the next edge. clr overrides any handshake on that cycle, so the beat or result is discarded.
- NBEATS=1: every accepted beat goes straight to OUT.
- No combinational path from in_* to out_*. in_ready depends only on state.
- No bit of acc is ever XORed with another share index. Share independence is preserved structurally, and all registers are kept (syn_keep/keep) so synthesis cannot merge shares.

## Timing
- Reset (rst_n=0, asynchronous): acc=0, cnt=0, state=ACC, so in_ready=1, out_valid=0, out_data=0.
- Reset asserted mid-fold or in OUT discards everything immediately. There is no partial output.
- Latency: out_valid rises on the edge that accepts the NBEATS-th beat, so it is visible 1 cycle after that beat's handshake.
- Throughput: NBEATS+1 cycles per result when out_ready is held high. The OUT cycle is a bubble, because input is never accepted in OUT.
- out_valid, once high, stays high with out_data unchanged until out_ready or clr.

## Configuration
- MSK_XOR_ACC_REFRESH_EN defined: the rnd port exists. Every accepted beat additionally XORs a zero-sum mask into the accumulator. For each bit j, shares i<d-1 take ^rnd[j*(d-1)+i], and share d-1 takes the XOR of all d-1 mask bits.
- The unmasked value is unchanged. Share values are re-randomised per beat.
- rnd is sampled only on accepted beats.
- d must be ≥2; elaboration errors if d=1.
- Undefined: no rnd port and no refresh logic. Output shares equal the exact share-wise XOR of the inputs.

## Test plan
- Basic fold (d=2, count=8, NBEATS=4, refresh off): beats with share pairs (0x11,0x22),(0x0F,0x00),(0xF0,0x01),(0x00,0x80) -> out_data shares (0xEE,0xA3) with out_valid 1 cycle after the 4th beat.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid stays 1, data stable, in_ready=0; out_ready=1 -> next cycle in_ready=1, acc=0.
- Gapped input: in_valid toggling 1,0,0,1,1,0,1 -> result identical to the back-to-back case; cnt advances only on handshakes.
- Abort/reset: clr after 2 beats, then 4 new beats -> result is the XOR of only the new 4. rst_n pulsed low in OUT -> out_valid=0 immediately.
- Refresh (macro on, d=3): random rnd, random beats -> XOR of the 3 output shares equals the XOR of the unmasked inputs. Shares differ from the no-refresh run for nonzero rnd.
- NBEATS=1: each accepted beat appears on out_data the next cycle, with one bubble between results.
